// File: rtl/cpu_run_controller_if.sv
// Program-load and instruction-memory write bundle for cpu_run_controller.
//   master : host/bench side, drives load_start/load_len/byte stream, observes
//            byte_ready and the imem write port.
//   slave  : controller side, accepts the byte stream and drives the imem port.
interface cpu_run_controller_if #(
  parameter int PC_W = 8
) ();
  logic            load_start;
  logic [PC_W:0]   load_len;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic            imem_we;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_wdata;

  modport master (
    output load_start, load_len, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Boot/run sequencer for top_cpu.
// Streams a program image into instruction memory while holding the CPU in
// reset, then releases reset and gates CPU commits (free-run or single-step).
// The CPU is stopped on a HALT opcode or when its PC leaves the loaded image.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   bus          load/byte stream and imem write port (slave modport)
//   run          pulse: start/restart the loaded program
//   step_mode    1 = single-step, 0 = free-run
//   step         step request, one instruction per rising edge
//   cpu_pc       current CPU PC
//   cpu_instr    instruction currently fetched by the CPU
//   cpu_reset    reset to the CPU
//   cpu_clk_en   CPU commits state this cycle
//   halted       CPU stopped by HALT or PC bound
//   error        sticky: illegal load_len, or run without a loaded program
//   cycle_count  instructions committed since last run (saturating)
//   state        FSM state encoding
module cpu_run_controller #(
  parameter int unsigned IMEM_BYTES  = 256,
  parameter int unsigned PC_W        = 8,
  parameter logic [3:0]  HALT_OPCODE = 4'hE
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_run_controller_if.slave  bus,
  input  logic                 run,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic [PC_W-1:0]      cpu_pc,
  input  logic [15:0]          cpu_instr,
  output logic                 cpu_reset,
  output logic                 cpu_clk_en,
  output logic                 halted,
  output logic                 error,
  output logic [15:0]          cycle_count,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_READY    = 3'd2,
    S_RST_HOLD = 3'd3,
    S_RUN      = 3'd4,
    S_HALTED   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W:0]   cnt_q, cnt_d;
  logic [PC_W:0]   len_q, len_d;
  logic            loaded_q, loaded_d;
  logic            error_q, error_d;
  logic            hold_q, hold_d;
  logic            step_q;
  logic [15:0]     cc_q, cc_d;
  logic            imem_we_q, imem_we_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [7:0]      imem_wdata_q, imem_wdata_d;

  logic len_ok;
  logic xfer;
  logic step_rise;
  logic halt_cond;
  logic clk_en;

  // Only the opcode nibble of the fetched instruction matters here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^cpu_instr[11:0];

  assign len_ok    = (bus.load_len != '0) && (32'(bus.load_len) <= IMEM_BYTES);
  assign xfer      = (state_q == S_LOAD) && bus.byte_valid;
  assign step_rise = step & ~step_q;
  assign halt_cond = (cpu_instr[15:12] == HALT_OPCODE) || ({1'b0, cpu_pc} >= len_q);
  assign clk_en    = (state_q == S_RUN) && !halt_cond && (!step_mode || step_rise);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    loaded_d     = loaded_q;
    error_d      = error_q;
    hold_d       = hold_q;
    cc_d         = cc_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_IDLE, S_READY, S_HALTED: begin
        // load_start wins over a simultaneous run, even when its length is illegal
        if (bus.load_start) begin
          if (len_ok) begin
            state_d  = S_LOAD;
            cnt_d    = '0;
            len_d    = bus.load_len;
            error_d  = 1'b0;
            loaded_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end else if (run) begin
          if (loaded_q) begin
            state_d = S_RST_HOLD;
            cc_d    = '0;
            hold_d  = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (xfer) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = cnt_q[PC_W-1:0];
          imem_wdata_d = bus.byte_data;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d  = S_READY;
            loaded_d = 1'b1;
          end
        end
      end

      S_RST_HOLD: begin
        if (hold_q) state_d = S_RUN;
        else        hold_d  = 1'b1;
      end

      S_RUN: begin
        if (clk_en && (cc_q != '1)) cc_d = cc_q + 1'b1;
        if (halt_cond) state_d = S_HALTED;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      loaded_q     <= 1'b0;
      error_q      <= 1'b0;
      hold_q       <= 1'b0;
      step_q       <= 1'b0;
      cc_q         <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      loaded_q     <= loaded_d;
      error_q      <= error_d;
      hold_q       <= hold_d;
      step_q       <= step;
      cc_q         <= cc_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign bus.byte_ready = (state_q == S_LOAD);
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_reset      = !((state_q == S_RUN) || (state_q == S_HALTED));
  assign cpu_clk_en     = clk_en;
  assign halted         = (state_q == S_HALTED);
  assign error          = error_q;
  assign cycle_count    = cc_q;
  assign state          = state_q;

endmodule
